seven_seg_scanner: RTL and testbench

- Downstream consumer of the three-digit seven-segment encoder outputs (SevenSegOne/Two/Three).
- Time-multiplexes the three 8-bit segment codes onto one shared segment bus with one-hot digit enables, for a common-segment multiplexed LED module.
- Double-buffers the incoming codes so an update never tears mid-frame.
- Inserts programmable dead time between digits to suppress ghosting.

---
 rtl/seven_seg_scanner.sv | 109 ++++++++++
 tb/tb_seven_seg_scanner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Three-digit multiplexed seven-segment scanner with a double-buffered code store
// and programmable dead time at the start of every digit slot.
module seven_seg_scanner #(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 500,
   parameter int CNT_W    = 16
) (
   input  logic       Clk,
   input  logic       RstN,
   input  logic       Enable,
   input  logic       Load,
   input  logic [7:0] SevenSegOne,
   input  logic [7:0] SevenSegTwo,
   input  logic [7:0] SevenSegThree,
   output logic [7:0] SegOut,
   output logic [2:0] DigitEn,
   output logic       FrameDone
);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK);

   logic [CNT_W-1:0] pre_cnt;
   logic [1:0]       idx;
   logic [7:0]       active  [3];
   logic [7:0]       pending [3];
   logic             pend_valid;

   logic             boundary;
   logic             transfer;
   logic             blanked;
   logic [7:0]       active_sel;

   // Frame boundary: last cycle of the last digit slot while scanning.
   assign boundary = Enable && (idx == 2'd2) && (pre_cnt == LAST_CNT);
   // While stopped nothing is on screen, so a pending update may land at once.
   assign transfer = boundary || (!Enable && pend_valid);
   assign blanked  = !Enable || (pre_cnt < BLANK_CNT) || (idx == 2'd3);

   always_comb begin
      active_sel = 8'h00;
      case (idx)
         2'd0:    active_sel = active[0];
         2'd1:    active_sel = active[1];
         2'd2:    active_sel = active[2];
         default: active_sel = 8'h00;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!RstN) begin
         pre_cnt    <= '0;
         idx        <= 2'd0;
         pend_valid <= 1'b0;
         SegOut     <= 8'h00;
         DigitEn    <= 3'b000;
         FrameDone  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            active[i]  <= 8'h00;
            pending[i] <= 8'h00;
         end
      end else begin
         // Code buffers: a load landing on a transfer bypasses straight to active.
         if (Load) begin
            pending[0] <= SevenSegOne;
            pending[1] <= SevenSegTwo;
            pending[2] <= SevenSegThree;
            if (transfer) begin
               active[0]  <= SevenSegOne;
               active[1]  <= SevenSegTwo;
               active[2]  <= SevenSegThree;
               pend_valid <= 1'b0;
            end else begin
               pend_valid <= 1'b1;
            end
         end else if (transfer) begin
            active[0]  <= pending[0];
            active[1]  <= pending[1];
            active[2]  <= pending[2];
            pend_valid <= 1'b0;
         end

         if (Enable) begin
            if (idx == 2'd3) begin
               idx <= 2'd0;
            end else if (pre_cnt == LAST_CNT) begin
               pre_cnt <= '0;
               idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
               pre_cnt <= pre_cnt + 1'b1;
            end
         end else begin
            pre_cnt <= '0;
            idx     <= 2'd0;
         end

         // Segment bus and digit enable share one register stage so they switch together.
         if (blanked) begin
            SegOut  <= 8'h00;
            DigitEn <= 3'b000;
         end else begin
            SegOut  <= active_sel;
            DigitEn <= 3'b001 << idx;
         end
         FrameDone <= boundary;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Cycle-by-cycle vector bench for seven_seg_scanner with PRESCALE=4, BLANK=1;
// each vector is one clock of inputs plus the outputs expected after that edge.
module tb_seven_seg_scanner;

   localparam int P = 4;
   localparam int B = 1;

   typedef struct {
      logic       rst_n;
      logic       en;
      logic       ld;
      logic [7:0] one;
      logic [7:0] two;
      logic [7:0] three;
      logic [7:0] exp_seg;
      logic [2:0] exp_dig;
      logic       exp_fd;
      logic       chk_pv;
      logic       exp_pv;
   } vec_t;

   logic       Clk = 1'b0;
   logic       RstN;
   logic       Enable;
   logic       Load;
   logic [7:0] SevenSegOne;
   logic [7:0] SevenSegTwo;
   logic [7:0] SevenSegThree;
   logic [7:0] SegOut;
   logic [2:0] DigitEn;
   logic       FrameDone;

   vec_t vecs[$];
   int   applied     = 0;
   int   miscompares = 0;
   logic pv_pending  = 1'b0;
   logic pv_value    = 1'b0;

   seven_seg_scanner #(.PRESCALE(P), .BLANK(B), .CNT_W(4)) dut (
      .Clk          (Clk),
      .RstN         (RstN),
      .Enable       (Enable),
      .Load         (Load),
      .SevenSegOne  (SevenSegOne),
      .SevenSegTwo  (SevenSegTwo),
      .SevenSegThree(SevenSegThree),
      .SegOut       (SegOut),
      .DigitEn      (DigitEn),
      .FrameDone    (FrameDone)
   );

   always #5 Clk = ~Clk;

   function automatic void add(logic rst_n, logic en, logic ld,
                               logic [7:0] one, logic [7:0] two, logic [7:0] three,
                               logic [7:0] seg, logic [2:0] dig, logic fd);
      vec_t v;
      v.rst_n = rst_n; v.en = en; v.ld = ld;
      v.one = one; v.two = two; v.three = three;
      v.exp_seg = seg; v.exp_dig = dig; v.exp_fd = fd;
      v.chk_pv = pv_pending; v.exp_pv = pv_value;
      pv_pending = 1'b0;
      vecs.push_back(v);
   endfunction

   function automatic void check_pv_next(logic v);
      pv_pending = 1'b1;
      pv_value   = v;
   endfunction

   // n cycles of an aligned, enabled frame showing a/b/c; optional load at cycle ld_k.
   function automatic void add_frame(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                     int ld_k, logic [7:0] na, logic [7:0] nb,
                                     logic [7:0] nc, int n);
      for (int k = 0; k < n; k++) begin
         int         slot;
         int         p;
         logic [7:0] seg;
         logic [2:0] dig;
         slot = k / P;
         p    = k % P;
         seg  = (slot == 0) ? a : (slot == 1) ? b : c;
         dig  = 3'b001 << slot;
         if (p < B) begin
            seg = 8'h00;
            dig = 3'b000;
         end
         if (ld_k >= 0 && k == ld_k + 1) check_pv_next(1'b1);
         add(1'b1, 1'b1, (k == ld_k), na, nb, nc, seg, dig, (k == 3 * P - 1));
      end
   endfunction

   task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vector %0d: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   initial begin
      // 1: reset with random inputs, then idle
      for (int i = 0; i < 2; i++)
         add(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'h00, 3'b000, 1'b0);
      check_pv_next(1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);

      // 2: load while stopped, transfer, then two scanned frames
      add(1'b1, 1'b0, 1'b1, 8'h3F, 8'h06, 8'h5B, 8'h00, 3'b000, 1'b0);
      check_pv_next(1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add_frame(8'h3F, 8'h06, 8'h5B, -1, 8'h00, 8'h00, 8'h00, 12);
      add_frame(8'h3F, 8'h06, 8'h5B, -1, 8'h00, 8'h00, 8'h00, 12);

      // 3: load during digit 1; current frame unchanged
      add_frame(8'h3F, 8'h06, 8'h5B, 5, 8'h66, 8'h6D, 8'h7D, 12);
      add_frame(8'h66, 8'h6D, 8'h7D, -1, 8'h00, 8'h00, 8'h00, 12);

      // 4: load exactly on the boundary cycle
      add_frame(8'h66, 8'h6D, 8'h7D, 11, 8'h07, 8'h7F, 8'h6F, 12);
      check_pv_next(1'b0);
      add_frame(8'h07, 8'h7F, 8'h6F, -1, 8'h00, 8'h00, 8'h00, 12);

      // 5: disable at idx=1, pre_cnt=2, then restart from digit 0
      add_frame(8'h07, 8'h7F, 8'h6F, -1, 8'h00, 8'h00, 8'h00, 6);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add_frame(8'h07, 8'h7F, 8'h6F, -1, 8'h00, 8'h00, 8'h00, 12);

      // 6: reset mid-frame with a pending load; everything cleared
      add_frame(8'h07, 8'h7F, 8'h6F, 1, 8'h11, 8'h22, 8'h33, 4);
      add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      check_pv_next(1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0);
      add_frame(8'h00, 8'h00, 8'h00, -1, 8'h00, 8'h00, 8'h00, 12);

      for (int i = 0; i < vecs.size(); i++) begin
         RstN          = vecs[i].rst_n;
         Enable        = vecs[i].en;
         Load          = vecs[i].ld;
         SevenSegOne   = vecs[i].one;
         SevenSegTwo   = vecs[i].two;
         SevenSegThree = vecs[i].three;
         @(posedge Clk);
         #1;
         applied++;
         check("seg_out", i, 32'(SegOut), 32'(vecs[i].exp_seg));
         check("digit_en", i, 32'(DigitEn), 32'(vecs[i].exp_dig));
         check("frame_done", i, 32'(FrameDone), 32'(vecs[i].exp_fd));
         if (vecs[i].chk_pv)
            check("pend_valid", i, 32'(dut.pend_valid), 32'(vecs[i].exp_pv));
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
